// File: rtl/icache_ctrl_gen.sv
// icache_ctrl_gen: parametrised instruction-cache controller.
// Sits between fetch and the tag/data arrays plus the memory read channel.
// Handles RD (hit, miss refill, uncached single-beat bypass), PREFETCH (refill
// without a response) and per-set INVAL (walks every way clearing valid).
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i/out_ready_o  request handshake (opcode_i, index_i, offset_i)
//   ptag_*                  translated tag channel (ptag_ready_o consumes)
//   out_valid_o/in_ready_i  read response handshake, rdata_o registered
//   lkp_*                   tag lookup strobe; hit/way return same cycle
//   rd_*                    data array read; rd_data_i valid next cycle
//   mem_req_*               refill request; mem_rvalid_i/mem_rdata_i beats
//   fill_*                  data array write during refill
//   tag_*                   tag/valid write (refill completion, INVAL)
module icache_ctrl_gen #(
  parameter int unsigned WAYS       = 8,
  parameter int unsigned INDEX_W    = 6,
  parameter int unsigned OFFSET_W   = 6,
  parameter int unsigned TAG_W      = 44,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LINE_BEATS = 8,
  localparam int unsigned WAY_W     = $clog2(WAYS),
  localparam int unsigned BEAT_W    = $clog2(LINE_BEATS),
  localparam int unsigned BSEL      = OFFSET_W - BEAT_W,
  localparam int unsigned ADDR_W    = TAG_W + INDEX_W + OFFSET_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // request
  input  logic                in_valid_i,
  input  logic [1:0]          opcode_i,
  input  logic [INDEX_W-1:0]  index_i,
  input  logic [OFFSET_W-1:0] offset_i,
  output logic                out_ready_o,
  // translated tag
  input  logic                ptag_valid_i,
  input  logic [TAG_W-1:0]    ptag_i,
  input  logic                ptag_uncache_i,
  output logic                ptag_ready_o,
  // response
  output logic                out_valid_o,
  output logic [DATA_W-1:0]   rdata_o,
  input  logic                in_ready_i,
  // tag lookup
  output logic                lkp_valid_o,
  output logic [INDEX_W-1:0]  lkp_index_o,
  output logic [TAG_W-1:0]    lkp_ptag_o,
  input  logic                lkp_hit_i,
  input  logic [WAY_W-1:0]    lkp_way_i,
  // data array read
  output logic                rd_en_o,
  output logic [WAY_W-1:0]    rd_way_o,
  output logic [INDEX_W-1:0]  rd_index_o,
  output logic [BEAT_W-1:0]   rd_beat_o,
  input  logic [DATA_W-1:0]   rd_data_i,
  // memory read channel
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  output logic                mem_req_single_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  // data array fill
  output logic                fill_we_o,
  output logic [WAY_W-1:0]    fill_way_o,
  output logic [INDEX_W-1:0]  fill_index_o,
  output logic [BEAT_W-1:0]   fill_beat_o,
  output logic [DATA_W-1:0]   fill_wdata_o,
  // tag write
  output logic                tag_we_o,
  output logic [WAY_W-1:0]    tag_way_o,
  output logic [INDEX_W-1:0]  tag_index_o,
  output logic [TAG_W-1:0]    tag_wdata_o,
  output logic                tag_wvalid_o
);

  typedef enum logic [2:0] {
    StIdle, StLookup, StRdWait, StMissReq, StRefill, StResp, StInval
  } state_e;

  typedef enum logic [1:0] {OpRd, OpPrefetch, OpInval, OpNop} op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [TAG_W-1:0]    ptag_q, ptag_d;
  logic                uncache_q, uncache_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WAY_W-1:0]    way_cnt_q, way_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // Beat within the line holding the requested word.
  logic [BEAT_W-1:0] crit_beat;
  assign crit_beat = offset_q[OFFSET_W-1:BSEL];

  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      op_q       <= OpRd;
      index_q    <= '0;
      offset_q   <= '0;
      way_q      <= '0;
      ptag_q     <= '0;
      uncache_q  <= 1'b0;
      beat_cnt_q <= '0;
      way_cnt_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      index_q    <= index_d;
      offset_q   <= offset_d;
      way_q      <= way_d;
      ptag_q     <= ptag_d;
      uncache_q  <= uncache_d;
      beat_cnt_q <= beat_cnt_d;
      way_cnt_q  <= way_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    index_d    = index_q;
    offset_d   = offset_q;
    way_d      = way_q;
    ptag_d     = ptag_q;
    uncache_d  = uncache_q;
    beat_cnt_d = beat_cnt_q;
    way_cnt_d  = way_cnt_q;
    rdata_d    = rdata_q;

    out_ready_o      = 1'b0;
    ptag_ready_o     = 1'b0;
    out_valid_o      = 1'b0;
    lkp_valid_o      = 1'b0;
    lkp_index_o      = '0;
    lkp_ptag_o       = '0;
    rd_en_o          = 1'b0;
    rd_way_o         = '0;
    rd_index_o       = '0;
    rd_beat_o        = '0;
    mem_req_valid_o  = 1'b0;
    mem_req_addr_o   = '0;
    mem_req_single_o = 1'b0;
    fill_we_o        = 1'b0;
    fill_way_o       = '0;
    fill_index_o     = '0;
    fill_beat_o      = '0;
    fill_wdata_o     = '0;
    tag_we_o         = 1'b0;
    tag_way_o        = '0;
    tag_index_o      = '0;
    tag_wdata_o      = '0;
    tag_wvalid_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        out_ready_o = 1'b1;
        if (in_valid_i) begin
          op_d     = op_e'(opcode_i);
          index_d  = index_i;
          offset_d = offset_i;
          unique case (op_e'(opcode_i))
            OpRd, OpPrefetch: state_d = StLookup;
            OpInval: begin
              way_cnt_d = '0;
              state_d   = StInval;
            end
            default: ; // reserved opcode is accepted and dropped
          endcase
        end
      end

      StLookup: begin
        ptag_ready_o = 1'b1;
        lkp_valid_o  = ptag_valid_i;
        lkp_index_o  = index_q;
        lkp_ptag_o   = ptag_i;
        if (ptag_valid_i) begin
          ptag_d    = ptag_i;
          uncache_d = ptag_uncache_i;
          if (ptag_uncache_i) begin
            // Bypass ignores whatever the array says about this address.
            state_d = StMissReq;
          end else if (lkp_hit_i) begin
            way_d = lkp_way_i;
            if (op_q == OpRd) begin
              rd_en_o    = 1'b1;
              rd_way_o   = lkp_way_i;
              rd_index_o = index_q;
              rd_beat_o  = crit_beat;
              state_d    = StRdWait;
            end else begin
              state_d = StIdle;
            end
          end else begin
            way_d   = lkp_way_i; // victim chosen by the array
            state_d = StMissReq;
          end
        end
      end

      StRdWait: begin
        rdata_d = rd_data_i;
        state_d = StResp;
      end

      StMissReq: begin
        mem_req_valid_o  = 1'b1;
        mem_req_single_o = uncache_q;
        mem_req_addr_o   = uncache_q ? {ptag_q, index_q, offset_q}
                                     : {ptag_q, index_q, {OFFSET_W{1'b0}}};
        if (mem_req_ready_i) begin
          beat_cnt_d = '0;
          state_d    = StRefill;
        end
      end

      StRefill: begin
        if (mem_rvalid_i) begin
          if (uncache_q) begin
            rdata_d = mem_rdata_i;
            state_d = (op_q == OpRd) ? StResp : StIdle;
          end else begin
            fill_we_o    = 1'b1;
            fill_way_o   = way_q;
            fill_index_o = index_q;
            fill_beat_o  = beat_cnt_q;
            fill_wdata_o = mem_rdata_i;
            if (beat_cnt_q == crit_beat) begin
              rdata_d = mem_rdata_i;
            end
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            // Final beat: validate the line and leave in the same cycle.
            if (beat_cnt_q == BEAT_W'(LINE_BEATS - 1)) begin
              tag_we_o     = 1'b1;
              tag_way_o    = way_q;
              tag_index_o  = index_q;
              tag_wdata_o  = ptag_q;
              tag_wvalid_o = 1'b1;
              state_d      = (op_q == OpRd) ? StResp : StIdle;
            end
          end
        end
      end

      StResp: begin
        out_valid_o = 1'b1;
        if (in_ready_i) begin
          state_d = StIdle;
        end
      end

      StInval: begin
        tag_we_o     = 1'b1;
        tag_way_o    = way_cnt_q;
        tag_index_o  = index_q;
        tag_wdata_o  = '0;
        tag_wvalid_o = 1'b0;
        way_cnt_d    = way_cnt_q + WAY_W'(1);
        if (way_cnt_q == WAY_W'(WAYS - 1)) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule
